feature_maxpool: RTL and testbench

//  Reader on the FEATURE RAM, the consumer of the feature map the convolver writes.
//  On start, it reads a FEATURE_WIDTH x FEATURE_WIDTH map of signed 2*BITWIDTH words and applies 2x2 max pooling, stride 2.
//  It writes the (FEATURE_WIDTH/2)^2 pooled words to the POOL RAM.
//  It sits between convolver eoc and the next layer; start is normally tied to eoc.

---
 rtl/feature_maxpool.sv | 142 ++++++++++++++
 tb/tb_feature_maxpool.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_maxpool.sv
// 2x2 stride-2 max pooling from the FEATURE RAM into the POOL RAM.
// Optional fused ReLU on the pooled value: define FEATURE_MAXPOOL_RELU_EN.
module feature_maxpool #(
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned FEATURE_WIDTH = 32,
  parameter int unsigned BITWIDTH      = 8,
  parameter int unsigned OUT_BASE      = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [2*BITWIDTH-1:0]   FEATURE_RAM_DIN,
  input  logic                    FEATURE_RAM_DATA_VAL,
  output logic                    FEATURE_RAM_EN,
  output logic [ADDR_WIDTH-1:0]   FEATURE_RAM_ADDRESS,
  output logic                    POOL_RAM_EN,
  output logic                    POOL_RAM_WEN,
  output logic [ADDR_WIDTH-1:0]   POOL_RAM_ADDRESS,
  output logic [2*BITWIDTH-1:0]   POOL_RAM_DOUT,
  output logic                    done
);

  localparam int unsigned POOL_W = FEATURE_WIDTH / 2;
  localparam int unsigned CNT_W  = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam int unsigned DW     = 2 * BITWIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POOL_W - 1);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrite, StDone} state_e;

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_pr, w_pr_nxt;
  logic [CNT_W-1:0]        r_pc, w_pc_nxt;
  logic [1:0]              r_k, w_k_nxt;
  logic signed [DW-1:0]    r_max, w_max_nxt;
  logic [DW-1:0]           r_dout, w_dout_nxt;
  logic [ADDR_WIDTH-1:0]   r_pool_addr, w_pool_addr_nxt;

  logic signed [DW-1:0]    w_din;
  logic signed [DW-1:0]    w_new_max;
  logic [DW-1:0]           w_pooled;
  logic [ADDR_WIDTH-1:0]   w_row, w_col, w_pool_addr;
  logic                    w_last_win;

  assign w_din = $signed(FEATURE_RAM_DIN);

  // Element k of the window: k[1] selects the lower row, k[0] the right column.
  assign w_row = (ADDR_WIDTH'(r_pr) << 1) + ADDR_WIDTH'(r_k[1]);
  assign w_col = (ADDR_WIDTH'(r_pc) << 1) + ADDR_WIDTH'(r_k[0]);
  assign FEATURE_RAM_ADDRESS = w_row * ADDR_WIDTH'(FEATURE_WIDTH) + w_col;

  assign w_pool_addr = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(r_pr) * ADDR_WIDTH'(POOL_W)
                     + ADDR_WIDTH'(r_pc);

  assign w_new_max  = (r_k == 2'd0 || w_din > r_max) ? w_din : r_max;
  assign w_last_win = (r_pr == LAST_IDX) && (r_pc == LAST_IDX);

`ifdef FEATURE_MAXPOOL_RELU_EN
  assign w_pooled = w_new_max[DW-1] ? '0 : w_new_max;
`else
  assign w_pooled = w_new_max;
`endif

  assign FEATURE_RAM_EN   = (r_state == StRdReq);
  assign POOL_RAM_EN      = (r_state == StWrite);
  assign POOL_RAM_WEN     = (r_state == StWrite);
  assign POOL_RAM_ADDRESS = r_pool_addr;
  assign POOL_RAM_DOUT    = r_dout;
  assign done             = (r_state == StDone);

  always_comb begin
    w_state_nxt     = r_state;
    w_pr_nxt        = r_pr;
    w_pc_nxt        = r_pc;
    w_k_nxt         = r_k;
    w_max_nxt       = r_max;
    w_dout_nxt      = r_dout;
    w_pool_addr_nxt = r_pool_addr;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = StRdReq;
          w_pr_nxt    = '0;
          w_pc_nxt    = '0;
          w_k_nxt     = '0;
        end
      end
      StRdReq: w_state_nxt = StRdWait;
      StRdWait: begin
        if (FEATURE_RAM_DATA_VAL) begin
          w_max_nxt = w_new_max;
          if (r_k == 2'd3) begin
            w_state_nxt     = StWrite;
            w_dout_nxt      = w_pooled;
            w_pool_addr_nxt = w_pool_addr;
          end else begin
            w_k_nxt     = r_k + 2'd1;
            w_state_nxt = StRdReq;
          end
        end
      end
      StWrite: begin
        w_k_nxt = '0;
        // Counters return to zero after the last window so DONE/IDLE show a clean address.
        if (w_last_win) begin
          w_pr_nxt    = '0;
          w_pc_nxt    = '0;
          w_state_nxt = StDone;
        end else begin
          w_state_nxt = StRdReq;
          if (r_pc == LAST_IDX) begin
            w_pc_nxt = '0;
            w_pr_nxt = r_pr + 1'b1;
          end else begin
            w_pc_nxt = r_pc + 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_pr        <= '0;
      r_pc        <= '0;
      r_k         <= '0;
      r_max       <= '0;
      r_dout      <= '0;
      r_pool_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pr        <= w_pr_nxt;
      r_pc        <= w_pc_nxt;
      r_k         <= w_k_nxt;
      r_max       <= w_max_nxt;
      r_dout      <= w_dout_nxt;
      r_pool_addr <= w_pool_addr_nxt;
    end
  end

endmodule

// File: tb/tb_feature_maxpool.sv
// Self-checking bench for feature_maxpool: RAM model with variable latency, reference pooling.
module tb_feature_maxpool;

  localparam int AW = 14;
  localparam int FW = 32;
  localparam int BW = 8;
  localparam int OB = 100;
  localparam int PW = FW / 2;
  localparam int NW = PW * PW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   din = '0;
  logic          dv = 1'b0;
  logic          feat_en, pool_en, pool_wen, done;
  logic [AW-1:0] feat_addr, pool_addr;
  logic [15:0]   pool_dout;

  always #5 clk = ~clk;

  feature_maxpool #(
    .ADDR_WIDTH(AW), .FEATURE_WIDTH(FW), .BITWIDTH(BW), .OUT_BASE(OB)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .start               (start),
    .FEATURE_RAM_DIN     (din),
    .FEATURE_RAM_DATA_VAL(dv),
    .FEATURE_RAM_EN      (feat_en),
    .FEATURE_RAM_ADDRESS (feat_addr),
    .POOL_RAM_EN         (pool_en),
    .POOL_RAM_WEN        (pool_wen),
    .POOL_RAM_ADDRESS    (pool_addr),
    .POOL_RAM_DOUT       (pool_dout),
    .done                (done)
  );

  logic signed [15:0] mem [FW*FW];
  logic [15:0]        expd [NW];
  logic [AW-1:0]      wr_addr_q [$];
  logic [15:0]        wr_data_q [$];
  int                 en_count = 0;
  int                 wen_bad = 0;
  bit                 spur_mode = 1'b0;
  bit                 randlat_mode = 1'b0;
  int                 n_checks = 0;
  int                 n_pass = 0;

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    logic [15:0] exp_raw, exp_relu;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FEATURE RAM: answers each EN after 1..5 cycles; optional junk DATA_VAL in RD_REQ/WRITE.
  int          ram_cnt = 0;
  logic [AW-1:0] ram_addr = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      dv      = 1'b0;
      ram_cnt = 0;
    end else begin
      dv = 1'b0;
      if (ram_cnt > 0) begin
        ram_cnt--;
        if (ram_cnt == 0) begin
          dv  = 1'b1;
          din = mem[ram_addr[9:0]];
        end
      end
      if (feat_en) begin
        en_count++;
        ram_addr = feat_addr;
        ram_cnt  = randlat_mode ? int'($urandom_range(5, 1)) : 1;
        if (spur_mode && $urandom_range(1, 0) == 1) begin
          dv  = 1'b1;
          din = 16'($urandom);
        end
      end
      if (pool_en) begin
        wr_addr_q.push_back(pool_addr);
        wr_data_q.push_back(pool_dout);
        if (pool_wen !== 1'b1) wen_bad++;
        if (spur_mode && $urandom_range(1, 0) == 1) begin
          dv  = 1'b1;
          din = 16'($urandom);
        end
      end
    end
  end

  // Reference: plain max over each 2x2 block.
  task automatic build_expected();
    for (int pr = 0; pr < PW; pr++) begin
      for (int pc = 0; pc < PW; pc++) begin
        int m;
        int v [4];
        v[0] = int'(mem[(2*pr)*FW + 2*pc]);
        v[1] = int'(mem[(2*pr)*FW + 2*pc + 1]);
        v[2] = int'(mem[(2*pr+1)*FW + 2*pc]);
        v[3] = int'(mem[(2*pr+1)*FW + 2*pc + 1]);
        m = v[0];
        for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
`ifdef FEATURE_MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        expd[pr*PW + pc] = 16'(m);
      end
    end
  endtask

  task automatic run_pass(input bit pokes, output int cyc, output int base, output int en0);
    base = wr_addr_q.size();
    en0  = en_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_to_en", 32'(feat_en), 32'd1);
    check("done_drop", 32'(done), 32'd0);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = pokes && !done && ($urandom_range(40, 0) == 0);
    end
    start = 1'b0;
    check("done_timeout", 32'(cyc < 20000), 32'd1);
  endtask

  task automatic compare_pass(input string tag, input int base, input int en0);
    int nw;
    nw = wr_addr_q.size() - base;
    check({tag, "_nwrites"}, 32'(nw), 32'(NW));
    check({tag, "_en_pulses"}, 32'(en_count - en0), 32'(4 * NW));
    check({tag, "_wen"}, 32'(wen_bad), 32'd0);
    for (int i = 0; i < NW && i < nw; i++) begin
      check({tag, "_addr"}, 32'(wr_addr_q[base + i]), 32'(AW'(OB + i)));
      check({tag, "_data"}, 32'(wr_data_q[base + i]), 32'(expd[i]));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < FW*FW; i++) mem[i] = 16'($urandom);
  endtask

  int cyc, base, en0, base2, en_snap;

  initial begin
    vecs[0] = '{w0: 16'hFFFB, w1: 16'hFFFE, w2: 16'hFFF7, w3: 16'hFFF9,
                exp_raw: 16'hFFFE, exp_relu: 16'h0000};
    vecs[1] = '{w0: 16'h0003, w1: 16'h0003, w2: 16'h0003, w3: 16'h0003,
                exp_raw: 16'h0003, exp_relu: 16'h0003};
    vecs[2] = '{w0: 16'h8000, w1: 16'h7FFF, w2: 16'h0000, w3: 16'hFFFF,
                exp_raw: 16'h7FFF, exp_relu: 16'h7FFF};
    vecs[3] = '{w0: 16'hFFFF, w1: 16'hFFFF, w2: 16'hFFFF, w3: 16'hFFFF,
                exp_raw: 16'hFFFF, exp_relu: 16'h0000};
    vecs[4] = '{w0: 16'h0064, w1: 16'hFF38, w2: 16'hFED4, w3: 16'h0063,
                exp_raw: 16'h0064, exp_relu: 16'h0064};

    repeat (3) @(negedge clk);
    check("rst_feat_en", 32'(feat_en), 32'd0);
    check("rst_feat_addr", 32'(feat_addr), 32'd0);
    check("rst_pool_en", 32'(pool_en | pool_wen), 32'd0);
    check("rst_pool_addr", 32'(pool_addr), 32'd0);
    check("rst_dout", 32'(pool_dout), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_en", 32'(en_count), 32'd0);

    // Ramp map, 1-cycle RAM
    for (int i = 0; i < FW*FW; i++) mem[i] = 16'(i);
    build_expected();
    run_pass(1'b0, cyc, base, en0);
    check("ramp_cycles", 32'(cyc), 32'd2304);
    compare_pass("ramp", base, en0);
    check("ramp_first", 32'(wr_data_q[base]), 32'd33);
    check("ramp_last", 32'(wr_data_q[base + NW - 1]), 32'd1023);
    repeat (4) @(negedge clk);
    check("done_holds", 32'(done), 32'd1);
    check("dout_holds", 32'(pool_dout), 32'd1023);

    // Ramp map again, random latency and junk DATA_VAL
    spur_mode    = 1'b1;
    randlat_mode = 1'b1;
    run_pass(1'b0, cyc, base, en0);
    compare_pass("ramp_lat", base, en0);
    spur_mode    = 1'b0;
    randlat_mode = 1'b0;

    // Signed window table at window (0,0)
    for (int v = 0; v < 5; v++) begin
      logic [15:0] want;
      fill_random();
      mem[0]      = vecs[v].w0;
      mem[1]      = vecs[v].w1;
      mem[FW]     = vecs[v].w2;
      mem[FW + 1] = vecs[v].w3;
`ifdef FEATURE_MAXPOOL_RELU_EN
      want = vecs[v].exp_relu;
`else
      want = vecs[v].exp_raw;
`endif
      build_expected();
      run_pass(1'b0, cyc, base, en0);
      check("vec_win0", 32'(wr_data_q[base]), 32'(want));
      compare_pass("vec", base, en0);
    end

    // start pokes during the run, then restart from DONE
    fill_random();
    build_expected();
    randlat_mode = 1'b1;
    run_pass(1'b1, cyc, base, en0);
    compare_pass("poke", base, en0);
    run_pass(1'b0, cyc, base, en0);
    compare_pass("restart", base, en0);
    randlat_mode = 1'b0;

    // All-equal 0x7FFF map
    for (int i = 0; i < FW*FW; i++) mem[i] = 16'h7FFF;
    build_expected();
    run_pass(1'b0, cyc, base, en0);
    compare_pass("flat", base, en0);
    check("flat_last_addr", 32'(wr_addr_q[base + NW - 1]), 32'd355);
    check("flat_last_data", 32'(wr_data_q[base + NW - 1]), 32'h7FFF);

    // Reset asserted in RD_WAIT of window 5
    base2 = wr_addr_q.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(wr_addr_q.size() - base2 == 5 && feat_en) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_win5", 32'(cyc < 2000), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_feat_en", 32'(feat_en), 32'd0);
    check("mid_rst_feat_addr", 32'(feat_addr), 32'd0);
    check("mid_rst_pool_en", 32'(pool_en | pool_wen), 32'd0);
    check("mid_rst_pool_addr", 32'(pool_addr), 32'd0);
    check("mid_rst_dout", 32'(pool_dout), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    resetn  = 1'b1;
    en_snap = en_count;
    repeat (10) @(negedge clk);
    check("post_rst_no_en", 32'(en_count - en_snap), 32'd0);
    check("post_rst_no_wr", 32'(wr_addr_q.size() - base2), 32'd5);
    check("post_rst_done", 32'(done), 32'd0);

    // Recovery pass after reset
    for (int i = 0; i < FW*FW; i++) mem[i] = 16'(i);
    build_expected();
    run_pass(1'b0, cyc, base, en0);
    check("recover_cycles", 32'(cyc), 32'd2304);
    compare_pass("recover", base, en0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
